// File: rtl/miner_pkg.sv
// Constants and types shared by the mining datapath: header framing, hashing and the nonce path.
package miner_pkg;

    localparam int unsigned HEADER_BYTES  = 80;
    localparam int unsigned HEADER_BITS   = HEADER_BYTES * 8;
    localparam int unsigned CLOCK_HZ      = 50_000_000;
    localparam int unsigned RX_TIMEOUT_MS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } assembler_state_e;

    function automatic int unsigned cycles_for_ms(input int unsigned ms);
        return (CLOCK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned RX_TIMEOUT_CYCLES = cycles_for_ms(RX_TIMEOUT_MS);

endpackage

// File: rtl/header_assembler_idle_timer.sv
// Saturating idle counter with clear and enable; 'terminal' flags the cycle whose
// clock edge steps the count onto TERMINAL, so the caller can react on that same edge.
module idle_timer #(
    parameter int unsigned TERMINAL = 99,
    parameter int unsigned WIDTH    = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] PRE_V  = WIDTH'(TERMINAL - 1);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Counter: clear wins, otherwise count while enabled and hold at TERMINAL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable && (count_r != TERM_V)) begin
            count_r <= count_r + ONE_V;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = enable && !clear && (count_r == PRE_V);

endmodule

// File: rtl/header_assembler.sv
// Collects UART bytes into a fixed-size block header with an inter-byte timeout and
// hands completed headers to the hash core through a valid/ack output register.
module header_assembler
    import miner_pkg::*;
#(
    parameter int unsigned BYTE_COUNT     = HEADER_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES,
    localparam int unsigned HEADER_WIDTH  = BYTE_COUNT * 8,
    localparam int unsigned COUNT_WIDTH   = $clog2(BYTE_COUNT + 1),
    localparam int unsigned TIMER_WIDTH   = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    header_ack,
    output logic [HEADER_WIDTH-1:0] header_data,
    output logic                    header_valid,
    output logic                    busy,
    output logic [COUNT_WIDTH-1:0]  byte_count,
    output logic                    timeout_pulse,
    output logic                    overrun_pulse,
    output logic                    overrun_flag
);

    localparam logic [COUNT_WIDTH-1:0] ZERO_COUNT = COUNT_WIDTH'(0);
    localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(BYTE_COUNT - 1);

    assembler_state_e              state_r;
    logic [HEADER_WIDTH-9:0]       shift_r;
    logic [COUNT_WIDTH-1:0]        byte_count_r;
    logic [HEADER_WIDTH-1:0]       header_data_r;
    logic                          header_valid_r;
    logic                          timeout_pulse_r;
    logic                          overrun_pulse_r;
    logic                          overrun_flag_r;

    logic [HEADER_WIDTH-1:0]       assembled_s;
    logic                          timer_clear_s;
    logic                          timer_enable_s;
    logic                          timer_terminal_s;

    // Next shift-register image and idle-timer controls.
    always_comb begin
        assembled_s    = {shift_r, rx_data};
        timer_enable_s = (state_r == RECV);
        timer_clear_s  = rx_valid || (state_r != RECV);
    end

    idle_timer #(
        .TERMINAL (TIMEOUT_CYCLES - 1),
        .WIDTH    (TIMER_WIDTH)
    ) u_idle_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear_s),
        .enable   (timer_enable_s),
        .terminal (timer_terminal_s)
    );

    // Framing FSM, output register and handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            shift_r         <= '0;
            byte_count_r    <= ZERO_COUNT;
            header_data_r   <= '0;
            header_valid_r  <= 1'b0;
            timeout_pulse_r <= 1'b0;
            overrun_pulse_r <= 1'b0;
            overrun_flag_r  <= 1'b0;
        end else begin
            timeout_pulse_r <= 1'b0;
            overrun_pulse_r <= 1'b0;
            if (header_ack && header_valid_r) begin
                header_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        shift_r      <= assembled_s[HEADER_WIDTH-9:0];
                        byte_count_r <= ONE_COUNT;
                        state_r      <= RECV;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        shift_r <= assembled_s[HEADER_WIDTH-9:0];
                        if (byte_count_r == LAST_COUNT) begin
                            byte_count_r <= ZERO_COUNT;
                            state_r      <= IDLE;
                            // An ack in the completion cycle frees the register for the new frame.
                            if (!header_valid_r || header_ack) begin
                                header_data_r  <= assembled_s;
                                header_valid_r <= 1'b1;
                            end else begin
                                overrun_pulse_r <= 1'b1;
                                overrun_flag_r  <= 1'b1;
                            end
                        end else begin
                            byte_count_r <= byte_count_r + ONE_COUNT;
                        end
                    end else if (timer_terminal_s) begin
                        byte_count_r    <= ZERO_COUNT;
                        timeout_pulse_r <= 1'b1;
                        state_r         <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    byte_count_r <= ZERO_COUNT;
                end
            endcase
        end
    end

    assign header_data   = header_data_r;
    assign header_valid  = header_valid_r;
    assign busy          = (state_r == RECV);
    assign byte_count    = byte_count_r;
    assign timeout_pulse = timeout_pulse_r;
    assign overrun_pulse = overrun_pulse_r;
    assign overrun_flag  = overrun_flag_r;

endmodule

// File: tb/tb_header_assembler.sv
// Self-checking bench for header_assembler: directed scenarios plus random traffic,
// every cycle compared against a queue-based frame model.
module tb_header_assembler;

    localparam int unsigned NB = 80;
    localparam int unsigned TO = 100;
    localparam int unsigned HW = NB * 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          header_ack;
    logic [HW-1:0] header_data;
    logic          header_valid;
    logic          busy;
    logic [6:0]    byte_count;
    logic          timeout_pulse;
    logic          overrun_pulse;
    logic          overrun_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]    m_asm[$];
    int            m_idle;
    logic [HW-1:0] m_hdr;
    logic          m_hv, m_to, m_ov, m_flag;
    logic [7:0]    frame_buf[NB];

    header_assembler #(.BYTE_COUNT(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .header_ack    (header_ack),
        .header_data   (header_data),
        .header_valid  (header_valid),
        .busy          (busy),
        .byte_count    (byte_count),
        .timeout_pulse (timeout_pulse),
        .overrun_pulse (overrun_pulse),
        .overrun_flag  (overrun_flag)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_asm.delete();
        m_idle = 0;
        m_hdr  = '0;
        m_hv   = 1'b0;
        m_to   = 1'b0;
        m_ov   = 1'b0;
        m_flag = 1'b0;
    endtask

    // One clock edge of the reference: bytes accumulate in a queue, a frame times out
    // after TO-1 consecutive byte-less edges, and a full queue becomes the header.
    task automatic model_step(input logic rv, input logic [7:0] d, input logic ack);
        logic [HW-1:0] full;
        bit done;
        full = '0;
        done = 1'b0;
        m_to = 1'b0;
        m_ov = 1'b0;
        if (rv) begin
            m_asm.push_back(d);
            m_idle = 0;
            if (m_asm.size() == NB) begin
                for (int i = 0; i < NB; i++) full[HW-1-8*i -: 8] = m_asm[i];
                m_asm.delete();
                done = 1'b1;
            end
        end else if (m_asm.size() != 0) begin
            m_idle++;
            if (m_idle == TO - 1) begin
                m_asm.delete();
                m_to = 1'b1;
            end
        end
        if (done) begin
            if (!m_hv || ack) begin
                m_hdr = full;
                m_hv  = 1'b1;
            end else begin
                m_ov   = 1'b1;
                m_flag = 1'b1;
            end
        end else if (ack) begin
            m_hv = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("header_valid", HW'(header_valid), HW'(m_hv));
        check_eq("header_data", header_data, m_hdr);
        check_eq("byte_count", HW'(byte_count), HW'(m_asm.size()));
        check_eq("busy", HW'(busy), HW'(m_asm.size() != 0));
        check_eq("timeout_pulse", HW'(timeout_pulse), HW'(m_to));
        check_eq("overrun_pulse", HW'(overrun_pulse), HW'(m_ov));
        check_eq("overrun_flag", HW'(overrun_flag), HW'(m_flag));
    endtask

    task automatic cycle(input logic rv, input logic [7:0] d, input logic ack);
        rx_valid   = rv;
        rx_data    = d;
        header_ack = ack;
        @(posedge clock);
        model_step(rv, d, ack);
        #1;
        cyc++;
        compare_all();
        rx_valid   = 1'b0;
        header_ack = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input int gap, input logic ack_last);
        for (int i = 0; i < NB; i++) begin
            cycle(1'b1, frame_buf[i], (i == NB - 1) ? ack_last : 1'b0);
            if (i < NB - 1) idle_cycles(gap);
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < NB; i++) frame_buf[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) frame_buf[i] = 8'($urandom);
    endtask

    function automatic logic [HW-1:0] packed_frame();
        logic [HW-1:0] v;
        for (int i = 0; i < NB; i++) v[HW-1-8*i -: 8] = frame_buf[i];
        return v;
    endfunction

    initial begin
        int k;
        int pulses;
        int pulse_at;
        logic [HW-1:0] exp_v;

        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        header_ack = 1'b0;
        model_reset();
        #2;
        check_eq("reset_valid", HW'(header_valid), HW'(1'b0));
        check_eq("reset_data", header_data, '0);
        check_eq("reset_count", HW'(byte_count), HW'(0));
        #10;
        reset = 1'b0;
        @(posedge clock);
        #1;
        compare_all();

        // Single frame, one byte every 10 cycles.
        for (int i = 0; i < NB; i++) frame_buf[i] = 8'(i);
        send_frame(9, 1'b0);
        check_eq("single_valid_rise", HW'(header_valid), HW'(1'b1));
        check_eq("single_first_byte", HW'(header_data[HW-1 -: 8]), HW'(8'h00));
        check_eq("single_last_byte", HW'(header_data[7:0]), HW'(8'h4F));
        check_eq("single_busy_fall", HW'(busy), HW'(1'b0));
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("single_ack_clear", HW'(header_valid), HW'(1'b0));

        // Timeout after ten bytes.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            idle_cycles($urandom_range(0, 3));
        end
        k = cyc;
        cycle(1'b1, 8'($urandom), 1'b0);
        pulses   = 0;
        pulse_at = -1;
        for (int j = 0; j < 150; j++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (timeout_pulse) begin
                pulses++;
                pulse_at = cyc;
                check_eq("timeout_count_zero", HW'(byte_count), HW'(0));
            end
        end
        check_eq("timeout_pulse_count", HW'(pulses), HW'(1));
        check_eq("timeout_latency", HW'(pulse_at - k), HW'(TO));
        fill_random();
        frame_buf[0] = 8'hAA;
        send_frame(0, 1'b0);
        check_eq("after_timeout_first", HW'(header_data[HW-1 -: 8]), HW'(8'hAA));
        cycle(1'b0, 8'h00, 1'b1);

        // Double buffer overrun.
        fill_const(8'h11);
        send_frame(0, 1'b0);
        fill_const(8'h22);
        send_frame(0, 1'b0);
        exp_v = {NB{8'h11}};
        check_eq("overrun_pulse_fire", HW'(overrun_pulse), HW'(1'b1));
        check_eq("overrun_flag_set", HW'(overrun_flag), HW'(1'b1));
        check_eq("overrun_data_kept", header_data, exp_v);
        cycle(1'b0, 8'h00, 1'b1);
        fill_const(8'h33);
        send_frame(0, 1'b0);
        exp_v = {NB{8'h33}};
        check_eq("frame_c_data", header_data, exp_v);

        // Completion on the same cycle as ack.
        fill_random();
        send_frame(1, 1'b1);
        check_eq("coinc_valid", HW'(header_valid), HW'(1'b1));
        check_eq("coinc_data", header_data, packed_frame());
        check_eq("coinc_no_overrun", HW'(overrun_pulse), HW'(1'b0));
        cycle(1'b0, 8'h00, 1'b1);

        // Sixth byte lands on the terminal idle cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'($urandom), 1'b0);
        pulses = 0;
        for (int j = 0; j < TO - 2; j++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (timeout_pulse) pulses++;
        end
        cycle(1'b1, 8'h5A, 1'b0);
        check_eq("edge_no_timeout", HW'(pulses + int'(timeout_pulse)), HW'(0));
        check_eq("edge_count_six", HW'(byte_count), HW'(6));
        idle_cycles(TO + 5);

        // Asynchronous reset mid-frame with a header pending.
        fill_random();
        send_frame(0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("arst_valid", HW'(header_valid), HW'(1'b0));
        check_eq("arst_busy", HW'(busy), HW'(1'b0));
        check_eq("arst_count", HW'(byte_count), HW'(0));
        check_eq("arst_data", header_data, '0);
        check_eq("arst_flag", HW'(overrun_flag), HW'(1'b0));
        #2;
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        fill_random();
        cycle(1'b1, frame_buf[0], 1'b0);
        check_eq("post_reset_count1", HW'(byte_count), HW'(1));
        for (int i = 1; i < NB; i++) cycle(1'b1, frame_buf[i], 1'b0);
        check_eq("post_reset_data", header_data, packed_frame());
        cycle(1'b0, 8'h00, 1'b1);

        // Random traffic with occasional long silences.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int j = 0; j < 120; j++) cycle(1'b0, 8'h00, $urandom_range(0, 7) == 0);
            end
            cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
